// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between two writeback requesters, the register-file write
// port and the arbiter that drives it.
interface regfile_write_arbiter_if #(
    parameter int DEPTH = 32,
    parameter int BITS  = 64
);
    localparam int AW = $clog2(DEPTH);

    logic            req0_valid;
    logic [AW-1:0]   req0_addr;
    logic [BITS-1:0] req0_data;
    logic            req0_ready;

    logic            req1_valid;
    logic [AW-1:0]   req1_addr;
    logic [BITS-1:0] req1_data;
    logic            req1_ready;

    logic [AW-1:0]   mem_addressw;
    logic [BITS-1:0] mem_writeData;
    logic            mem_writeEn;
    logic            init_done;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  mem_addressw, mem_writeData, mem_writeEn, init_done
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output mem_addressw, mem_writeData, mem_writeEn, init_done
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port controller: zero sweep after reset, then round-robin
// sharing of the write port between two requesters; x0 writes are swallowed.
module regfile_write_arbiter #(
    parameter int DEPTH = 32,
    parameter int BITS  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   cnt;
    logic            prio;
    logic            grant_valid;
    logic            grant_sel;
    logic [AW-1:0]   grant_addr;
    logic [BITS-1:0] grant_data;
    logic            handshake;

    always_comb begin
        grant_valid = bus.req0_valid | bus.req1_valid;
        grant_sel   = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_sel = prio;
        end else if (bus.req1_valid) begin
            grant_sel = 1'b1;
        end
        grant_addr = grant_sel ? bus.req1_addr : bus.req0_addr;
        grant_data = grant_sel ? bus.req1_data : bus.req0_data;
    end

    // Ready is only the grant qualified by RUN, so a grant always completes.
    always_comb begin
        handshake      = (state == RUN) && grant_valid;
        bus.req0_ready = handshake && !grant_sel;
        bus.req1_ready = handshake && grant_sel;
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (cnt == LAST) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt               <= '0;
            prio              <= 1'b0;
            bus.mem_writeEn   <= 1'b0;
            bus.mem_addressw  <= '0;
            bus.mem_writeData <= '0;
            bus.init_done     <= 1'b0;
        end else if (state == INIT) begin
            bus.mem_writeEn   <= 1'b1;
            bus.mem_addressw  <= cnt;
            bus.mem_writeData <= '0;
            cnt               <= cnt + AW'(1);
            if (cnt == LAST) begin
                bus.init_done <= 1'b1;
            end
        end else if (handshake) begin
            bus.mem_addressw  <= grant_addr;
            bus.mem_writeData <= grant_data;
            bus.mem_writeEn   <= (grant_addr != '0);
            prio              <= ~grant_sel;
        end else begin
            bus.mem_writeEn   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a negedge-write register-file model.
module tb_regfile_write_arbiter;
    localparam int DEPTH = 32;
    localparam int BITS  = 64;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DEPTH(DEPTH), .BITS(BITS)) bus ();

    regfile_write_arbiter #(.DEPTH(DEPTH), .BITS(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Storage model: no reset of its own, so reset scribbles non-zero junk into it.
    logic [BITS-1:0] mem [DEPTH];
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 64'hBAD0_0000_0000_0000 | 64'(i);
        end else if (bus.mem_writeEn) begin
            mem[bus.mem_addressw] <= bus.mem_writeData;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    endtask

    task automatic test_reset();
        idle();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #2;
        vectors++; if (bus.mem_writeEn !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", bus.mem_writeEn); end
        vectors++; if (bus.mem_addressw !== 5'd0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", bus.mem_addressw); end
        vectors++; if (bus.mem_writeData !== 64'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", bus.mem_writeData); end
        vectors++; if (bus.init_done !== 1'b0) begin miscompares++; $display("FAIL reset_init_done got %b want 0", bus.init_done); end
        vectors++; if (bus.req0_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready0 got %b want 0", bus.req0_ready); end
        vectors++; if (bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready1 got %b want 0", bus.req1_ready); end
        idle();
        tick();
        tick();
        vectors++; if (bus.mem_writeEn !== 1'b0) begin miscompares++; $display("FAIL reset_held_we got %b want 0", bus.mem_writeEn); end
    endtask

    task automatic test_sweep();
        rst = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            vectors++; if (bus.mem_writeEn !== 1'b1) begin miscompares++; $display("FAIL sweep_we[%0d] got %b want 1", k, bus.mem_writeEn); end
            vectors++; if (bus.mem_addressw !== 5'(k - 1)) begin miscompares++; $display("FAIL sweep_addr[%0d] got %0d want %0d", k, bus.mem_addressw, k - 1); end
            vectors++; if (bus.mem_writeData !== 64'd0) begin miscompares++; $display("FAIL sweep_data[%0d] got %h want 0", k, bus.mem_writeData); end
            vectors++; if (bus.init_done !== (k == DEPTH)) begin miscompares++; $display("FAIL sweep_init_done[%0d] got %b want %b", k, bus.init_done, k == DEPTH); end
        end
        tick();
        vectors++; if (bus.mem_writeEn !== 1'b0) begin miscompares++; $display("FAIL sweep_end_we got %b want 0", bus.mem_writeEn); end
        vectors++; if (bus.init_done !== 1'b1) begin miscompares++; $display("FAIL sweep_end_init_done got %b want 1", bus.init_done); end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (mem[i] !== 64'd0) begin miscompares++; $display("FAIL sweep_readback[%0d] got %h want 0", i, mem[i]); end
        end
    endtask

    task automatic test_single();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 64'hDEAD_BEEF;
        #1;
        vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready0 got %b want 1", bus.req0_ready); end
        vectors++; if (bus.req1_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready1 got %b want 0", bus.req1_ready); end
        tick();
        vectors++; if (bus.mem_writeEn !== 1'b1) begin miscompares++; $display("FAIL single_we got %b want 1", bus.mem_writeEn); end
        vectors++; if (bus.mem_addressw !== 5'd5) begin miscompares++; $display("FAIL single_addr got %0d want 5", bus.mem_addressw); end
        vectors++; if (bus.mem_writeData !== 64'hDEAD_BEEF) begin miscompares++; $display("FAIL single_data got %h want deadbeef", bus.mem_writeData); end
        idle();
        tick();
        vectors++; if (bus.mem_writeEn !== 1'b0) begin miscompares++; $display("FAIL single_after_we got %b want 0", bus.mem_writeEn); end
        vectors++; if (mem[5] !== 64'hDEAD_BEEF) begin miscompares++; $display("FAIL single_readback got %h want deadbeef", mem[5]); end
    endtask

    task automatic test_x0();
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 64'hFF;
        #1;
        vectors++; if (bus.req1_ready !== 1'b1) begin miscompares++; $display("FAIL x0_ready1 got %b want 1", bus.req1_ready); end
        tick();
        vectors++; if (bus.mem_writeEn !== 1'b0) begin miscompares++; $display("FAIL x0_we got %b want 0", bus.mem_writeEn); end
        vectors++; if (bus.mem_addressw !== 5'd0) begin miscompares++; $display("FAIL x0_addr got %0d want 0", bus.mem_addressw); end
        vectors++; if (bus.mem_writeData !== 64'hFF) begin miscompares++; $display("FAIL x0_data got %h want ff", bus.mem_writeData); end
        idle();
        tick();
        vectors++; if (mem[0] !== 64'd0) begin miscompares++; $display("FAIL x0_readback got %h want 0", mem[0]); end
    endtask

    // Enters with prio = 0 because the x0 handshake came from requester 1.
    task automatic test_contention();
        logic [AW-1:0] exp_addr [8];
        int i0;
        int i1;
        exp_addr = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 8; c++) begin
            bus.req0_valid = (i0 < 4); bus.req0_addr = 5'(1 + i0);
            bus.req0_data  = 64'hA000_0000_0000_0000 | 64'(1 + i0);
            bus.req1_valid = (i1 < 4); bus.req1_addr = 5'(9 + i1);
            bus.req1_data  = 64'hA000_0000_0000_0000 | 64'(9 + i1);
            #1;
            vectors++; if (bus.req0_ready !== (c % 2 == 0)) begin miscompares++; $display("FAIL cont_ready0[%0d] got %b want %b", c, bus.req0_ready, c % 2 == 0); end
            vectors++; if (bus.req1_ready !== (c % 2 == 1)) begin miscompares++; $display("FAIL cont_ready1[%0d] got %b want %b", c, bus.req1_ready, c % 2 == 1); end
            tick();
            vectors++; if (bus.mem_writeEn !== 1'b1) begin miscompares++; $display("FAIL cont_we[%0d] got %b want 1", c, bus.mem_writeEn); end
            vectors++; if (bus.mem_addressw !== exp_addr[c]) begin miscompares++; $display("FAIL cont_addr[%0d] got %0d want %0d", c, bus.mem_addressw, exp_addr[c]); end
            vectors++; if (bus.mem_writeData !== (64'hA000_0000_0000_0000 | 64'(exp_addr[c]))) begin miscompares++; $display("FAIL cont_data[%0d] got %h want %h", c, bus.mem_writeData, 64'hA000_0000_0000_0000 | 64'(exp_addr[c])); end
            if (c % 2 == 0) i0++; else i1++;
        end
        idle();
        tick();
        vectors++; if (bus.mem_writeEn !== 1'b0) begin miscompares++; $display("FAIL cont_after_we got %b want 0", bus.mem_writeEn); end
        for (int c = 0; c < 8; c++) begin
            vectors++; if (mem[exp_addr[c]] !== (64'hA000_0000_0000_0000 | 64'(exp_addr[c]))) begin miscompares++; $display("FAIL cont_readback[%0d] got %h", exp_addr[c], mem[exp_addr[c]]); end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 3; c++) begin
            bus.req0_valid = 1'b1; bus.req0_addr = 5'(2 + c);
            bus.req0_data  = 64'h0202_0000_0000_0000 | 64'(2 + c);
            #1;
            vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready0[%0d] got %b want 1", c, bus.req0_ready); end
            tick();
            vectors++; if (bus.mem_writeEn !== 1'b1) begin miscompares++; $display("FAIL b2b_we[%0d] got %b want 1", c, bus.mem_writeEn); end
            vectors++; if (bus.mem_addressw !== 5'(2 + c)) begin miscompares++; $display("FAIL b2b_addr[%0d] got %0d want %0d", c, bus.mem_addressw, 2 + c); end
        end
        idle();
        tick();
        vectors++; if (bus.mem_writeEn !== 1'b0) begin miscompares++; $display("FAIL b2b_after_we got %b want 0", bus.mem_writeEn); end
        vectors++; if (bus.mem_addressw !== 5'd4) begin miscompares++; $display("FAIL b2b_hold_addr got %0d want 4", bus.mem_addressw); end
        vectors++; if (bus.mem_writeData !== 64'h0202_0000_0000_0004) begin miscompares++; $display("FAIL b2b_hold_data got %h want 0202000000000004", bus.mem_writeData); end
        for (int c = 2; c <= 4; c++) begin
            vectors++; if (mem[c] !== (64'h0202_0000_0000_0000 | 64'(c))) begin miscompares++; $display("FAIL b2b_readback[%0d] got %h", c, mem[c]); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 11; k++) tick();
        vectors++; if (bus.mem_addressw !== 5'd10) begin miscompares++; $display("FAIL mid_pre_addr got %0d want 10", bus.mem_addressw); end
        vectors++; if (bus.mem_writeEn !== 1'b1) begin miscompares++; $display("FAIL mid_pre_we got %b want 1", bus.mem_writeEn); end
        rst = 1'b1;
        #1;
        vectors++; if (bus.mem_writeEn !== 1'b0) begin miscompares++; $display("FAIL mid_async_we got %b want 0", bus.mem_writeEn); end
        vectors++; if (bus.mem_addressw !== 5'd0) begin miscompares++; $display("FAIL mid_async_addr got %0d want 0", bus.mem_addressw); end
        tick();
        tick();
        vectors++; if (bus.mem_writeEn !== 1'b0) begin miscompares++; $display("FAIL mid_held_we got %b want 0", bus.mem_writeEn); end
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 64'h77;
        #1;
        vectors++; if (bus.req0_ready !== 1'b0) begin miscompares++; $display("FAIL mid_ready0_init got %b want 0", bus.req0_ready); end
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            vectors++; if (bus.mem_addressw !== 5'(k - 1)) begin miscompares++; $display("FAIL mid_sweep_addr[%0d] got %0d want %0d", k, bus.mem_addressw, k - 1); end
            vectors++; if (bus.mem_writeEn !== 1'b1) begin miscompares++; $display("FAIL mid_sweep_we[%0d] got %b want 1", k, bus.mem_writeEn); end
            vectors++; if (bus.init_done !== (k == DEPTH)) begin miscompares++; $display("FAIL mid_init_done[%0d] got %b want %b", k, bus.init_done, k == DEPTH); end
            vectors++; if (bus.req0_ready !== (k == DEPTH)) begin miscompares++; $display("FAIL mid_ready0[%0d] got %b want %b", k, bus.req0_ready, k == DEPTH); end
        end
        tick();
        vectors++; if (bus.mem_writeEn !== 1'b1) begin miscompares++; $display("FAIL mid_first_we got %b want 1", bus.mem_writeEn); end
        vectors++; if (bus.mem_addressw !== 5'd7) begin miscompares++; $display("FAIL mid_first_addr got %0d want 7", bus.mem_addressw); end
        vectors++; if (bus.mem_writeData !== 64'h77) begin miscompares++; $display("FAIL mid_first_data got %h want 77", bus.mem_writeData); end
        idle();
        tick();
        vectors++; if (bus.mem_writeEn !== 1'b0) begin miscompares++; $display("FAIL mid_after_we got %b want 0", bus.mem_writeEn); end
        vectors++; if (mem[7] !== 64'h77) begin miscompares++; $display("FAIL mid_readback got %h want 77", mem[7]); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_single();
        test_x0();
        test_contention();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
